// File: rtl/user_packet_framer_pkg.sv
// User packet framer shared types.
// Header layout, FSM states and the framed output word.
package user_packet_framer_pkg;

  localparam int DATA_W = 128;

  localparam int HDR_DST_LSB  = 0;
  localparam int HDR_DST_W    = 8;
  localparam int HDR_SRC_LSB  = 8;
  localparam int HDR_SRC_W    = 8;
  localparam int HDR_TYPE_LSB = 16;
  localparam int HDR_TYPE_W   = 4;
  localparam int HDR_LEN_LSB  = 20;
  localparam int HDR_LEN_W    = 8;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
  } PacketWord;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DRAIN
  } fsm_state_t;

  function automatic logic [DATA_W-1:0] make_header(
    input logic [HDR_DST_W-1:0]  dst,
    input logic [HDR_SRC_W-1:0]  src,
    input logic [HDR_TYPE_W-1:0] typ,
    input logic [HDR_LEN_W-1:0]  len
  );
    logic [DATA_W-1:0] h;
    h = '0;
    h[HDR_DST_LSB  +: HDR_DST_W]  = dst;
    h[HDR_SRC_LSB  +: HDR_SRC_W]  = src;
    h[HDR_TYPE_LSB +: HDR_TYPE_W] = typ;
    h[HDR_LEN_LSB  +: HDR_LEN_W]  = len;
    return h;
  endfunction

endpackage

// File: rtl/user_packet_framer_if.sv
// Request, payload and framed TX channels of the packet framer.
// master is the user side, slave is the framer.
interface user_packet_framer_if;
  import user_packet_framer_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [HDR_DST_W-1:0]   req_dst;
  logic [HDR_TYPE_W-1:0]  req_type;
  logic [HDR_LEN_W-1:0]   req_len;

  logic                   payload_valid;
  logic                   payload_ready;
  logic [DATA_W-1:0]      payload_data;
  logic                   payload_last;

  PacketWord              packet_tx;
  logic                   packet_tx_ready;

  modport master (
    output req_valid,
    output req_dst,
    output req_type,
    output req_len,
    input  req_ready,
    output payload_valid,
    output payload_data,
    output payload_last,
    input  payload_ready,
    input  packet_tx,
    output packet_tx_ready
  );

  modport slave (
    input  req_valid,
    input  req_dst,
    input  req_type,
    input  req_len,
    output req_ready,
    input  payload_valid,
    input  payload_data,
    input  payload_last,
    output payload_ready,
    output packet_tx,
    input  packet_tx_ready
  );

endinterface

// File: rtl/user_packet_framer_out_reg.sv
// Single-entry output register with valid/ready.
// A held word never changes until it transfers.
module framer_out_reg
  import user_packet_framer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              last,
  output logic              loadable,
  output PacketWord         word,
  input  logic              ready
);

  assign loadable = !word.valid || ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word <= '0;
    end else if (loadable) begin
      word.valid <= load;
      if (load) begin
        word.data <= data;
        word.last <= last;
      end
    end
  end

endmodule

// File: rtl/user_packet_framer.sv
// Frames a request plus payload beats into header + payload words.
// Length mismatches are truncated or drained and counted as errors.
module user_packet_framer
  import user_packet_framer_pkg::*;
#(
  parameter int          MAX_LINES = 16,
  parameter logic [7:0]  SRC_ID    = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  user_packet_framer_if.slave   bus,
  output logic [31:0]           packets_sent,
  output logic [19:0]           tx_lines,
  output logic [7:0]            error_count
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_LINES);

  fsm_state_t             state;
  fsm_state_t             state_nx;

  logic [HDR_DST_W-1:0]   dst_q;
  logic [HDR_TYPE_W-1:0]  type_q;
  logic [HDR_LEN_W-1:0]   len_q;
  logic [7:0]             beat_cnt;
  logic [8:0]             beat_num;
  logic                   at_len;
  logic                   req_ok;

  logic                   loadable;
  logic                   load;
  logic [DATA_W-1:0]      ld_data;
  logic                   ld_last;

  logic                   latch_req;
  logic                   clr_beat;
  logic                   inc_beat;
  logic                   inc_err;
  logic                   inc_sent;

  assign req_ok   = (bus.req_len != 8'd0) && (bus.req_len <= MAX_LEN);
  assign beat_num = {1'b0, beat_cnt} + 9'd1;
  assign at_len   = beat_num == {1'b0, len_q};

  always_comb begin
    state_nx          = state;
    bus.req_ready     = 1'b0;
    bus.payload_ready = 1'b0;
    load              = 1'b0;
    ld_data           = bus.payload_data;
    ld_last           = 1'b0;
    latch_req         = 1'b0;
    clr_beat          = 1'b0;
    inc_beat          = 1'b0;
    inc_err           = 1'b0;
    inc_sent          = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          bus.req_ready = 1'b1;
          if (req_ok) begin
            latch_req = 1'b1;
            clr_beat  = 1'b1;
            state_nx  = HEADER;
          end else begin
            inc_err = 1'b1;
          end
        end
      end
      HEADER: begin
        if (loadable) begin
          load     = 1'b1;
          ld_data  = make_header(dst_q, SRC_ID, type_q, len_q);
          state_nx = PAYLOAD;
        end
      end
      PAYLOAD: begin
        bus.payload_ready = loadable;
        if (bus.payload_valid && loadable) begin
          load     = 1'b1;
          inc_beat = 1'b1;
          ld_last  = at_len || bus.payload_last;
          if (ld_last) begin
            inc_sent = 1'b1;
            // early last or missing last are both mismatches
            inc_err  = at_len != bus.payload_last;
            state_nx = (at_len && !bus.payload_last) ? DRAIN : IDLE;
          end
        end
      end
      DRAIN: begin
        bus.payload_ready = 1'b1;
        if (bus.payload_valid && bus.payload_last) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!rst_n) begin
      bus.req_ready     = 1'b0;
      bus.payload_ready = 1'b0;
      load              = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dst_q        <= '0;
      type_q       <= '0;
      len_q        <= '0;
      beat_cnt     <= '0;
      packets_sent <= '0;
      tx_lines     <= '0;
      error_count  <= '0;
    end else begin
      if (latch_req) begin
        dst_q  <= bus.req_dst;
        type_q <= bus.req_type;
        len_q  <= bus.req_len;
      end
      if (clr_beat) begin
        beat_cnt <= '0;
      end else if (inc_beat) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (inc_sent) begin
        packets_sent <= packets_sent + 32'd1;
      end
      if (inc_err && error_count != 8'hFF) begin
        error_count <= error_count + 8'd1;
      end
      if (bus.packet_tx.valid && bus.packet_tx_ready) begin
        tx_lines <= tx_lines + 20'd1;
      end
    end
  end

  framer_out_reg u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .data     (ld_data),
    .last     (ld_last),
    .loadable (loadable),
    .word     (bus.packet_tx),
    .ready    (bus.packet_tx_ready)
  );

endmodule
